uart_top: RTL and testbench
===========================

// Module: uart_top
// PURPOSE
//  Full-duplex 8N1 UART: byte-parallel TX with a busy handshake and RX with a one-byte holding
//  register, RXNE flag and overrun flag. Serves as host-side serial link to the bus bridge/LED top
//  and as a bench-side byte injector. One clock, no internal bus interface.
// PARAMETERS
//  CLK_FREQ_HZ  12_000_000  system clock frequency
//  BAUD_RATE    115_200     line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division, 104 at defaults)
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  i_reset_n     in   1  asynchronous, active-low reset
//  in_w_data     in   8  TX byte, sampled when in_valid accepted
//  in_valid      in   1  TX request pulse
//  out_BUSY      out  1  TX frame in progress
//  out_signal    out  1  TX serial line, idle high
//  in_signal     in   1  RX serial line (asynchronous)
//  in_RXNE_clear in   1  clears out_RXNE and out_Rx_ORE
//  out_word      out  8  last received byte
//  out_RXNE      out  1  receive register not empty
//  out_Rx_ORE    out  1  overrun: byte completed while out_RXNE=1
// BEHAVIOUR
//  Reset: out_signal=1, out_BUSY=0, out_word=0, out_RXNE=0, out_Rx_ORE=0, both FSMs IDLE.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each state CLKS_PER_BIT cycles.
//  - in_valid=1 with out_BUSY=0 at edge n: byte latched; out_signal=0 and out_BUSY=1 from n+1.
//  - in_valid while out_BUSY=1: ignored, no queueing. in_w_data changes after acceptance: no effect.
//  - out_BUSY falls on the edge the stop bit ends (10*CLKS_PER_BIT cycles after n+1); a new
//    in_valid in that same cycle-with-BUSY=0 starts the next frame back-to-back.
//  RX: in_signal passes a 2-FF synchroniser (reset value 1). FSM IDLE->START->DATA->STOP->IDLE.
//  - Falling edge in IDLE enters START; line re-sampled at CLKS_PER_BIT/2; if high: false start, IDLE.
//  - Data bits sampled at bit centres (every CLKS_PER_BIT), LSB first.
//  - Stop sampled at its centre; FSM returns to IDLE right away (tolerates back-to-back frames).
//  - Stop=1, RXNE=0: out_word<=byte, out_RXNE<=1 on the next edge.
//  - Stop=1, RXNE=1: out_Rx_ORE<=1; out_word keeps old byte, new byte discarded.
//  - Stop=0 (framing error): byte discarded, flags unchanged (see CONFIGURATION).
//  - in_RXNE_clear=1: RXNE, ORE (and FE) cleared next edge. Simultaneous with a completing byte:
//    completion wins: out_word updated, RXNE=1, ORE=0.
//  - Counters sized $clog2(CLKS_PER_BIT)+1; no wrap within a bit. TX and RX fully independent.
//  - Reset mid-frame: both FSMs abort immediately; out_signal high, partial byte lost.
// CONFIGURATION
//  UART_RX_FE_EN defined: extra output out_Rx_FE (1 bit, reset 0), set when a stop bit samples 0,
//  cleared by in_RXNE_clear (same priority rule as ORE). Not defined: port absent, bad frames
//  silently dropped.
// STRUCTURE
//  Package uart_pkg: tx_state_t/rx_state_t enums, function clks_per_bit(freq,baud), DATA_BITS=8.
//  Sub-module uart_rx_core (synchroniser, RX FSM, shift register); TX FSM and RX holding
//  register/flags live in uart_top.
// TESTING (bench: CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000 -> 16 clk/bit)
//  1 TX 0x53 -> line 0,1,1,0,0,1,0,1,0,1 each 16 clk; out_BUSY high exactly 160 cycles.
//  2 Loopback out_signal->in_signal, send 0x41 -> out_word=0x41, out_RXNE=1, ORE=0; clear -> RXNE=0.
//  3 Send 0x31 then 0x34, no clear -> out_word=0x31, RXNE=1, ORE=1; in_RXNE_clear -> both 0.
//  4 in_signal low 4 cycles then high -> no RXNE, RX FSM back to IDLE; next 0x52 received OK.
//  5 i_reset_n low mid-TX of 0x57 -> out_signal=1, out_BUSY=0 immediately; next in_valid sends cleanly.
//  6 UART_RX_FE_EN: frame 0x36 with stop=0 -> out_Rx_FE=1, RXNE=0; clear -> out_Rx_FE=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART (uart_top / uart_rx_core).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive path: 2-FF input synchroniser, start/data/stop FSM and shift register.
// Emits a one-cycle done pulse with the assembled byte and the sampled stop-bit level.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic                 done_o,
  output logic                 stop_ok_o,
  output logic [DATA_BITS-1:0] byte_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // Half-bit check rejects glitches shorter than half a bit period.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = RX_STOP;
          else idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          ok_d    = sync2_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  assign done_o    = done_q;
  assign stop_ok_o = ok_q;
  assign byte_o    = shreg_q;

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: TX FSM with busy handshake, RX holding register with RXNE/overrun flags.
// Define UART_RX_FE_EN to add the out_Rx_FE framing-error flag output.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       i_reset_n,
  input  logic [7:0] in_w_data,
  input  logic       in_valid,
  output logic       out_BUSY,
  output logic       out_signal,
  input  logic       in_signal,
  input  logic       in_RXNE_clear,
  output logic [7:0] out_word,
  output logic       out_RXNE,
  output logic       out_Rx_ORE
`ifdef UART_RX_FE_EN
  ,
  output logic       out_Rx_FE
`endif
);

  localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_busy_q, tx_busy_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (in_valid) begin
          tx_shreg_d = in_w_data;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_line_d  = tx_shreg_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_LAST) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_line_d  = tx_shreg_q[1];
            tx_shreg_d = tx_shreg_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        // Dropping busy here lets a waiting request start the next frame one cycle later.
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_busy_d  = 1'b0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign out_signal = tx_line_q;
  assign out_BUSY   = tx_busy_q;

  logic                 rx_done;
  logic                 rx_stop_ok;
  logic [DATA_BITS-1:0] rx_byte;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk      (clk),
    .rst_n    (i_reset_n),
    .rx_i     (in_signal),
    .done_o   (rx_done),
    .stop_ok_o(rx_stop_ok),
    .byte_o   (rx_byte)
  );

  logic [7:0] word_q, word_d;
  logic       rxne_q, rxne_d;
  logic       ore_q, ore_d;
`ifdef UART_RX_FE_EN
  logic       fe_q, fe_d;
`endif

  // Clear is applied first so a byte completing in the same cycle overrides it.
  always_comb begin
    word_d = word_q;
    rxne_d = rxne_q;
    ore_d  = ore_q;
`ifdef UART_RX_FE_EN
    fe_d   = fe_q;
`endif
    if (in_RXNE_clear) begin
      rxne_d = 1'b0;
      ore_d  = 1'b0;
`ifdef UART_RX_FE_EN
      fe_d   = 1'b0;
`endif
    end
    if (rx_done) begin
      if (rx_stop_ok) begin
        if (!rxne_q || in_RXNE_clear) begin
          word_d = rx_byte;
          rxne_d = 1'b1;
        end else begin
          ore_d = 1'b1;
        end
      end else begin
`ifdef UART_RX_FE_EN
        fe_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_q <= '0;
      rxne_q <= 1'b0;
      ore_q  <= 1'b0;
`ifdef UART_RX_FE_EN
      fe_q   <= 1'b0;
`endif
    end else begin
      word_q <= word_d;
      rxne_q <= rxne_d;
      ore_q  <= ore_d;
`ifdef UART_RX_FE_EN
      fe_q   <= fe_d;
`endif
    end
  end

  assign out_word   = word_q;
  assign out_RXNE   = rxne_q;
  assign out_Rx_ORE = ore_q;
`ifdef UART_RX_FE_EN
  assign out_Rx_FE  = fe_q;
`endif

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top at 16 clocks per bit: TX line monitor and RX flag monitor
// check against queues filled by the stimulus from a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_top;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b1;
  logic [7:0] in_w_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_BUSY;
  logic       out_signal;
  logic       in_signal;
  logic       in_RXNE_clear = 1'b0;
  logic [7:0] out_word;
  logic       out_RXNE;
  logic       out_Rx_ORE;
  logic       fe_obs;
`ifdef UART_RX_FE_EN
  logic       out_Rx_FE;
  assign fe_obs = out_Rx_FE;
`else
  assign fe_obs = 1'b0;
`endif

  logic loopback = 1'b0;
  logic tb_line  = 1'b1;
  assign in_signal = loopback ? out_signal : tb_line;

  always #5 clk = ~clk;

  uart_top #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .in_w_data    (in_w_data),
    .in_valid     (in_valid),
    .out_BUSY     (out_BUSY),
    .out_signal   (out_signal),
    .in_signal    (in_signal),
    .in_RXNE_clear(in_RXNE_clear),
    .out_word     (out_word),
    .out_RXNE     (out_RXNE),
    .out_Rx_ORE   (out_Rx_ORE)
`ifdef UART_RX_FE_EN
    ,
    .out_Rx_FE    (out_Rx_FE)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int rst_epoch = 0;

  logic [7:0]  tx_exp[$];
  logic [10:0] rx_exp[$];   // {word, rxne, ore, fe}

  // Reference model of the receive holding register
  logic [7:0]  m_word = 8'h00;
  logic        m_rxne = 1'b0, m_ore = 1'b0, m_fe = 1'b0;
  logic [10:0] m_last = 11'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic model_push();
    logic [10:0] s;
    s = {m_word, m_rxne, m_ore, m_fe};
    if (s != m_last) begin
      rx_exp.push_back(s);
      m_last = s;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (!m_rxne) begin
        m_word = b;
        m_rxne = 1'b1;
      end else begin
        m_ore = 1'b1;
      end
    end else begin
`ifdef UART_RX_FE_EN
      m_fe = 1'b1;
`endif
    end
    model_push();
  endtask

  task automatic model_clear();
    m_rxne = 1'b0;
    m_ore  = 1'b0;
    m_fe   = 1'b0;
    model_push();
  endtask

  task automatic model_reset();
    m_word = 8'h00;
    model_clear();
  endtask

  // RX monitor: every visible change of the flag/word outputs must match the next model state
  logic [10:0] rx_seen = 11'h000;
  logic [10:0] rx_cur, rx_want;
  always @(negedge clk) begin
    rx_cur = {out_word, out_RXNE, out_Rx_ORE, fe_obs};
    if (rx_cur !== rx_seen) begin
      if (rx_exp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no change from 0x%0h", rx_cur, rx_seen);
      end else begin
        rx_want = rx_exp.pop_front();
        check("rx_state{word,rxne,ore,fe}", {21'd0, rx_cur}, {21'd0, rx_want});
      end
      rx_seen = rx_cur;
    end
  end

  // TX monitor: compares every cycle of each frame to the ideal 10-bit waveform
  int         tx_ep, tx_werr, tx_idx;
  logic [7:0] tx_acc, tx_expb;
  logic       tx_have, tx_lvl;
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset_n === 1'b1 && out_signal === 1'b0) begin
        tx_ep   = rst_epoch;
        tx_werr = 0;
        tx_acc  = 8'h00;
        tx_have = (tx_exp.size() > 0);
        tx_expb = tx_have ? tx_exp[0] : 8'h00;
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk);
          tx_idx = c / CPB;
          tx_lvl = (tx_idx == 0) ? 1'b0 : (tx_idx == 9) ? 1'b1 : tx_expb[tx_idx-1];
          if (out_signal !== tx_lvl) tx_werr++;
          if ((c % CPB) == CPB / 2 && tx_idx >= 1 && tx_idx <= 8) tx_acc[tx_idx-1] = out_signal;
        end
        if (tx_ep != rst_epoch) begin
          if (tx_exp.size() > 0) void'(tx_exp.pop_front());
        end else if (!tx_have) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got frame 0x%0h, expected no frame", tx_acc);
        end else begin
          void'(tx_exp.pop_front());
          check("tx_byte", {24'd0, tx_acc}, {24'd0, tx_expb});
          check("tx_wave_bad_cycles", tx_werr, 0);
        end
      end
    end
  end

  task automatic wait_busy_low(output int n);
    n = 0;
    while (out_BUSY === 1'b1 && n < 400) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (loopback) model_frame(b, 1'b1);
    tx_exp.push_back(b);
    @(negedge clk);
    in_w_data = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_w_data = 8'($urandom);
    wait_busy_low(n);
    check("tx_busy_cycles", n, 10 * CPB);
    repeat (4) @(posedge clk);
  endtask

  task automatic send_b2b(input logic [7:0] a, input logic [7:0] b);
    int n;
    if (loopback) begin
      model_frame(a, 1'b1);
      model_frame(b, 1'b1);
    end
    tx_exp.push_back(a);
    tx_exp.push_back(b);
    @(negedge clk);
    in_w_data = a;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_w_data = b;   // held request while busy must be ignored until the frame ends
    wait_busy_low(n);
    check("b2b_first_busy_cycles", n, 10 * CPB);
    @(posedge clk);
    #1;
    check("b2b_restart_busy", {31'd0, out_BUSY}, 32'd1);
    in_valid = 1'b0;
    wait_busy_low(n);
    check("b2b_second_busy_cycles", n, 10 * CPB);
    repeat (4) @(posedge clk);
  endtask

  task automatic drive_line(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    tb_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    tb_line = stop_bit;
    repeat (CPB) @(negedge clk);
    tb_line = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_clear();
    model_clear();
    @(negedge clk);
    in_RXNE_clear = 1'b1;
    @(negedge clk);
    in_RXNE_clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic held_clear_frame(input logic [7:0] b);
    @(negedge clk);
    in_RXNE_clear = 1'b1;
    model_clear();
    model_frame(b, 1'b1);
    model_clear();
    drive_line(b, 1'b1);
    in_RXNE_clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r1, r2;
    #1 i_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_signal", {31'd0, out_signal}, 32'd1);
    check("reset_busy", {31'd0, out_BUSY}, 32'd0);
    check("reset_word", {24'd0, out_word}, 32'd0);
    check("reset_rxne", {31'd0, out_RXNE}, 32'd0);
    check("reset_ore", {31'd0, out_Rx_ORE}, 32'd0);
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // TX waveform of 0x53
    send_byte(8'h53);

    // Loopback receive and clear
    loopback = 1'b1;
    send_byte(8'h41);
    do_clear();

    // Overrun: second byte discarded, ORE set
    send_byte(8'h31);
    send_byte(8'h34);
    do_clear();

    // False start, then a good frame
    loopback = 1'b0;
    @(negedge clk);
    tb_line = 1'b0;
    repeat (4) @(negedge clk);
    tb_line = 1'b1;
    repeat (40) @(negedge clk);
    model_frame(8'h52, 1'b1);
    drive_line(8'h52, 1'b1);
    do_clear();

    // Reset in the middle of a TX frame (during a low data bit of 0x57)
    loopback = 1'b1;
    tx_exp.push_back(8'h57);
    @(negedge clk);
    in_w_data = 8'h57;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    #2;
    model_reset();
    rst_epoch++;
    i_reset_n = 1'b0;
    #1;
    check("midreset_signal", {31'd0, out_signal}, 32'd1);
    check("midreset_busy", {31'd0, out_BUSY}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (200) @(posedge clk);
    send_byte(8'h57);
    do_clear();

    // Framing error: byte dropped (FE flag when enabled)
    loopback = 1'b0;
    model_frame(8'h36, 1'b0);
    drive_line(8'h36, 1'b0);
    do_clear();

    // Clear held across a completing byte: completion wins for that cycle
    held_clear_frame(8'h7E);

    // Randomized mix
    for (int it = 0; it < 16; it++) begin
      r1 = 8'($urandom);
      case ($urandom_range(0, 4))
        0: begin loopback = 1'b1; send_byte(r1); loopback = 1'b0; end
        1: begin model_frame(r1, 1'b1); drive_line(r1, 1'b1); end
        2: begin model_frame(r1, 1'b0); drive_line(r1, 1'b0); end
        3: do_clear();
        default: held_clear_frame(r1);
      endcase
    end

    // Back-to-back frames over loopback
    do_clear();
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    loopback = 1'b1;
    send_b2b(r1, r2);
    do_clear();

    repeat (50) @(posedge clk);
    check("tx_queue_left", tx_exp.size(), 0);
    check("rx_queue_left", rx_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
